// File: rtl/moving_sum_filter.sv
// Sliding-window accumulator over the last DEPTH accepted samples. It provides a
// full-precision running sum and a rounded, saturated average.
module moving_sum_filter #(
   parameter int DATA_W    = 12,
   parameter int DEPTH     = 9,
   parameter int AVG_SHIFT = 3,
   localparam int SUM_W    = DATA_W + $clog2(DEPTH),
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [SUM_W-1:0]  out_sum,
   output logic [DATA_W-1:0] out_avg,
   output logic [CNT_W-1:0]  fill_cnt,
   output logic              primed
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int MAX_V = 2**DATA_W - 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [SUM_W:0]    acc;

   always_comb begin
      mem_d       = mem_q;
      sum_d       = sum_q;
      wr_ptr_d    = wr_ptr_q;
      fill_cnt_d  = fill_cnt_q;
      out_valid_d = 1'b0;
      // The evicted slot is always <= the running sum, so the extra bit only carries.
      acc = {1'b0, sum_q} + (SUM_W+1)'(in_data) - (SUM_W+1)'(mem_q[wr_ptr_q]);
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
         sum_d      = '0;
         wr_ptr_d   = '0;
         fill_cnt_d = '0;
      end else if (in_valid) begin
         mem_d[wr_ptr_q] = in_data;
         sum_d           = SUM_W'(acc);
         wr_ptr_d        = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (fill_cnt_q != CNT_W'(DEPTH)) fill_cnt_d = fill_cnt_q + 1'b1;
         out_valid_d     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         sum_q       <= '0;
         wr_ptr_q    <= '0;
         fill_cnt_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         sum_q       <= sum_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_cnt_q  <= fill_cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_sum   = sum_q;
   assign fill_cnt  = fill_cnt_q;
   assign out_valid = out_valid_q;
   assign primed    = (fill_cnt_q == CNT_W'(DEPTH));

   generate
      if (AVG_SHIFT == 0) begin : g_noshift
         assign out_avg = (sum_q > SUM_W'(MAX_V)) ? DATA_W'(MAX_V) : sum_q[DATA_W-1:0];
      end else begin : g_shift
         logic [SUM_W:0] rnd;
         // Round half up before shifting; one spare bit absorbs the rounding carry.
         assign rnd     = ({1'b0, sum_q} + (SUM_W+1)'(2**(AVG_SHIFT-1))) >> AVG_SHIFT;
         assign out_avg = (rnd > (SUM_W+1)'(MAX_V)) ? DATA_W'(MAX_V) : rnd[DATA_W-1:0];
      end
   endgenerate

endmodule
